wb_uart: RTL
============

WB_UART -- requirements
Module: wb_uart

Interface
REQ-001 Parameter DIV_RESET, default 16'd433, reset value of DIVISOR; bit period = DIVISOR+1 clk cycles.
REQ-002 Parameter TX_DEPTH, default 4, TX FIFO entries, power of 2, >=2.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 cyc  in  1  Wishbone cycle.
REQ-006 stb  in  1  Wishbone strobe.
REQ-007 we  in  1  write enable.
REQ-008 adr  in  16  address; only adr[2:1] decoded.
REQ-009 dat_i  in  16  write data.
REQ-010 dat_o  out  16  read data, valid with ack.
REQ-011 ack  out  1  pipelined-mode acknowledge.
REQ-012 stall  out  1  pipelined-mode stall.
REQ-013 txd  out  1  serial out, idle high.
REQ-014 rxd  in  1  serial in, asynchronous.
REQ-015 irq  out  1  level interrupt.

Function
REQ-016 Request accepted in cycle where cyc & stb & !stall; ack SHALL be 1 exactly one cycle later, for one cycle, per accepted request; back-to-back accepts SHALL give back-to-back acks.
REQ-017 stall SHALL be combinational: 1 iff cyc & stb & we & adr[2:1]==0 & TX FIFO full; all other requests never stall.
REQ-018 Register map by adr[2:1]: 0 DATA, 1 STATUS, 2 DIVISOR, 3 reserved (reads 0, writes ignored).
REQ-019 DATA write: push dat_i[7:0] into TX FIFO. DATA read: return {8'h00, RXBUF}, clear RXVALID.
REQ-020 STATUS read-only: bit0 TX full, bit1 TX FIFO empty, bit2 TX shifter busy, bit3 RXVALID, bit4 OVERRUN, bit5 FRAMERR, bits15:6 zero; STATUS read clears bits 4 and 5 after returning them.
REQ-021 DIVISOR read/write, 16 bit; new value used from next bit boundary; in-flight bit unaffected.
REQ-022 dat_o SHALL be 0 in cycles without ack.
REQ-023 TX FSM IDLE->START->DATA->STOP->IDLE; IDLE with FIFO non-empty pops head and enters START next edge; START drives 0, DATA drives 8 bits LSB first, STOP drives 1, each one bit period; STOP end with FIFO non-empty goes directly to START (no idle gap).
REQ-024 Simultaneous FIFO push and pop SHALL leave count unchanged; push while full impossible (stalled).
REQ-025 RX: rxd through 2-flop synchronizer; FSM IDLE->START->DATA->STOP; falling edge in IDLE starts count; START samples at DIVISOR>>1 clocks, returns to IDLE if high (glitch); DATA and STOP sample every DIVISOR+1 clocks thereafter.
REQ-026 STOP sample: byte written to RXBUF, RXVALID=1; stop bit low additionally sets FRAMERR.
REQ-027 Byte completion with RXVALID already 1 and no same-cycle DATA read: OVERRUN=1, RXBUF keeps old byte; same-cycle DATA read: new byte stored, RXVALID stays 1, no overrun.
REQ-028 irq = RXVALID | (TX FIFO empty & !busy).

Reset
REQ-029 rst low at clock edge: txd=1, ack=0, dat_o=0, FIFOs empty, both FSMs IDLE, RXVALID/OVERRUN/FRAMERR=0, RXBUF=0, DIVISOR=DIV_RESET; in-flight frames aborted, no completion.
REQ-030 After reset STATUS reads 16'h0002, irq=1.

Configuration
REQ-031 Macro WB_UART_RX_EN defined: receiver per REQ-025..027 present.
REQ-032 Macro undefined: no RX logic; rxd ignored; STATUS bits 3..5 read 0; DATA read returns 0; irq = TX FIFO empty & !busy; TX and bus timing unchanged.

Verification (DIV=3 -> 4 clocks/bit)
REQ-033 Reset low 2 cycles then high -> txd=1, STATUS read 16'h0002, ack one cycle after request.
REQ-034 Write DATA 16'h0055 -> txd: 0 for 4 clocks, then 1,0,1,0,1,0,1,0 each 4 clocks, then 1; frame 40 clocks; STATUS bit2=1 during frame.
REQ-035 Six back-to-back DATA writes from idle -> writes 1-5 accepted no stall, write 6 stalls until byte 1 STOP ends, then acked; six frames with no idle gaps.
REQ-036 Drive rxd frame 8'hA3 (WB_UART_RX_EN) -> STATUS 16'h000A...bit3=1, DATA read 16'h00A3, next STATUS bit3=0.
REQ-037 Two frames 8'h11, 8'h22 without read -> STATUS bit4=1, DATA reads 16'h0011; second STATUS read bit4=0.
REQ-038 rst low mid-frame of 16'h00F0 -> txd=1 next cycle, STATUS 16'h0002, no remaining bits transmitted.

Source files
------------

// File: rtl/wb_uart.sv
// wb_uart: Wishbone pipelined-mode UART with a TX FIFO, programmable divisor and level irq.
// Define WB_UART_RX_EN to build the receiver; without it the block is transmit-only.
module wb_uart #(
  parameter logic [15:0] DIV_RESET = 16'd433,
  parameter int          TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [15:0] adr,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  output logic        ack,
  output logic        stall,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);

  localparam int PTR_W = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [15:0]      divisor;
  logic [7:0]       fifo_mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic             accept, rd_status, wr_div;
  logic [15:0]      rd_mux, status;

  tx_state_t        tx_state, tx_state_n;
  logic [15:0]      tx_cnt;
  logic [2:0]       tx_idx;
  logic [7:0]       tx_shift;
  logic             tx_bit_end, tx_busy;

  logic             rx_valid, rx_overrun, rx_framerr;
  logic [7:0]       rx_buf;
  logic             unused_adr;

  assign unused_adr = ^{adr[15:3], adr[0]};

  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(TX_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  assign stall     = cyc & stb & we & (adr[2:1] == 2'd0) & fifo_full;
  assign accept    = cyc & stb & ~stall;
  assign push      = accept & we & (adr[2:1] == 2'd0);
  assign wr_div    = accept & we & (adr[2:1] == 2'd2);
  assign rd_status = accept & ~we & (adr[2:1] == 2'd1);

  assign tx_busy = (tx_state != TX_IDLE);
  assign status  = {10'd0, rx_framerr, rx_overrun, rx_valid, tx_busy, fifo_empty, fifo_full};
  assign irq     = rx_valid | (fifo_empty & ~tx_busy);

  always_comb begin
    rd_mux = 16'h0000;
    case (adr[2:1])
      2'd0:    rd_mux = {8'h00, rx_buf};
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = divisor;
      default: rd_mux = 16'h0000;
    endcase
  end

  // Bus response stage: ack and read data one cycle after acceptance
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack     <= 1'b0;
      dat_o   <= 16'h0000;
      divisor <= DIV_RESET;
    end else begin
      ack   <= accept;
      dat_o <= (accept && !we) ? rd_mux : 16'h0000;
      if (wr_div) divisor <= dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= dat_i[7:0];
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (!rst) tx_state <= TX_IDLE;
    else      tx_state <= tx_state_n;
  end

  always_comb begin
    tx_state_n = tx_state;
    pop        = 1'b0;
    tx_bit_end = (tx_cnt == 16'd0);
    case (tx_state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_state_n = TX_START;
        end
      end
      TX_START: if (tx_bit_end) tx_state_n = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_state_n = TX_STOP;
      TX_STOP: begin
        if (tx_bit_end) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            tx_state_n = TX_START;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // The bit counter reloads from divisor at every bit boundary, so a divisor
  // write only affects bits that start after it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      txd    <= 1'b1;
      tx_cnt <= 16'd0;
      tx_idx <= 3'd0;
    end else if (pop) begin
      txd    <= 1'b0;
      tx_cnt <= divisor;
    end else if (tx_state != TX_IDLE) begin
      if (tx_bit_end) begin
        tx_cnt <= divisor;
        case (tx_state)
          TX_START: begin
            txd    <= tx_shift[0];
            tx_idx <= 3'd0;
          end
          TX_DATA: begin
            txd    <= (tx_idx == 3'd7) ? 1'b1 : tx_shift[0];
            tx_idx <= tx_idx + 3'd1;
          end
          default: txd <= 1'b1;
        endcase
      end else begin
        tx_cnt <= tx_cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop)
      tx_shift <= fifo_mem[rd_ptr];
    else if (tx_bit_end && (tx_state == TX_START || tx_state == TX_DATA))
      tx_shift <= {1'b0, tx_shift[7:1]};
  end

`ifdef WB_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   rx_state, rx_state_n;
  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift;
  logic        rx_tick, rx_fall, rx_done, rd_data;

  assign rd_data = accept & ~we & (adr[2:1] == 2'd0);
  assign rx_tick = (rx_cnt == 16'd0);
  assign rx_fall = rx_prev & ~rx_s2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_done    = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_n = RX_START;
      RX_START: if (rx_tick) rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_idx == 3'd7) rx_state_n = RX_STOP;
      RX_STOP: begin
        if (rx_tick) begin
          rx_done    = 1'b1;
          rx_state_n = RX_IDLE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Start-bit check lands mid-bit; later samples are one bit period apart
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_cnt <= 16'd0;
      rx_idx <= 3'd0;
    end else begin
      case (rx_state)
        RX_IDLE: if (rx_fall) rx_cnt <= {1'b0, divisor[15:1]};
        RX_START: begin
          if (rx_tick) begin
            rx_cnt <= divisor;
            rx_idx <= 3'd0;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: begin
          if (rx_tick) begin
            rx_cnt <= divisor;
            rx_idx <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_tick) rx_shift <= {rx_s2, rx_shift[7:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_buf     <= 8'h00;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_framerr <= 1'b0;
    end else begin
      if (rd_data) rx_valid <= 1'b0;
      if (rd_status) begin
        rx_overrun <= 1'b0;
        rx_framerr <= 1'b0;
      end
      if (rx_done) begin
        if (rx_valid && !rd_data) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_buf   <= rx_shift;
          rx_valid <= 1'b1;
        end
        if (!rx_s2) rx_framerr <= 1'b1;
      end
    end
  end
`else
  logic unused_rx;

  assign unused_rx  = rxd ^ rd_status;
  assign rx_buf     = 8'h00;
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign rx_framerr = 1'b0;
`endif

endmodule
